// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared logic-analyzer types and constants
// Used by the sampler and the capture readout engine.
package la_pkg;

    localparam int LA_ADDR_W = 10;
    localparam int LA_DEPTH  = 1024;
    localparam logic [7:0] LA_SYNC0 = 8'h55;
    localparam logic [7:0] LA_SYNC1 = 8'hAA;

    // Readout engine states; prefixed so they cannot collide with the
    // HDR0/HDR1 sync-byte parameters of the readout block.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR0   = 3'd1,
        ST_HDR1   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } la_state_e;

endpackage

// File: rtl/readout_buf2.sv
// rtl/readout_buf2.sv - 2-entry sample FIFO between capture RAM and stream
// Ports: clk, rst_pll (async active-low), flush (drop all entries),
//        push/push_data (write), pop (advance head), count (0..2), head (oldest entry).
module readout_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_pll,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Flush has priority so a read returning on the cancel cycle is discarded.
    always_ff @(posedge clk or negedge rst_pll) begin
        if (!rst_pll) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - flow-controlled capture RAM reader with sync header
// Ports: clk, rst_pll (async active-low); cap_done/start_addr start a dump;
//        abort cancels it; rd_en/rd_addr/rd_data talk to the capture RAM
//        (1-cycle read latency); m_data/m_valid/m_ready carry the byte stream;
//        busy is high outside IDLE, done pulses once after the last sample.
module capture_readout
    import la_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              ADDR_W = LA_ADDR_W,
    parameter int              DEPTH  = LA_DEPTH,
    parameter logic [DATA_W-1:0] HDR0 = LA_SYNC0,
    parameter logic [DATA_W-1:0] HDR1 = LA_SYNC1
) (
    input  logic              clk,
    input  logic              rst_pll,
    input  logic              cap_done,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    la_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   sent_q, sent_d;
    logic              inflight_q;

    logic              fetch_en;
    logic              pop;
    logic              push;
    logic              flush;
    logic [1:0]        buf_count;
    logic [DATA_W-1:0] buf_head;
    logic [1:0]        occ_eff;

    always_ff @(posedge clk or negedge rst_pll) begin
        if (!rst_pll) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= rd_en;
        end
    end

    // A read issued last cycle only lands while still fetching; after an
    // abort the state is IDLE and the returning word is dropped.
    assign push = inflight_q && (state_q == ST_HDR1 || state_q == ST_STREAM);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        m_valid  = 1'b0;
        m_data   = '0;
        done     = 1'b0;
        rd_en    = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        fetch_en = 1'b0;
        occ_eff  = 2'd0;
        busy     = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                flush = 1'b1;
                if (cap_done && !abort) begin
                    state_d  = ST_HDR0;
                    addr_d   = start_addr;
                    issued_d = '0;
                    sent_d   = '0;
                end
            end
            ST_HDR0: begin
                m_valid = 1'b1;
                m_data  = HDR0;
                if (m_ready) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                m_valid  = 1'b1;
                m_data   = HDR1;
                fetch_en = 1'b1;
                if (m_ready) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                m_valid  = (buf_count != 2'd0);
                m_data   = buf_head;
                fetch_en = 1'b1;
                if (m_valid && m_ready) begin
                    pop    = 1'b1;
                    sent_d = sent_q + 1'b1;
                    if (sent_q == DEPTH_C - 1'b1) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Occupancy counts the slot freed by this cycle's pop, otherwise the
        // two-slot window would only reach two samples every three cycles.
        occ_eff = buf_count + {1'b0, inflight_q} - {1'b0, pop};
        if (fetch_en && !abort && issued_q < DEPTH_C && occ_eff < 2'd2) begin
            rd_en    = 1'b1;
            addr_d   = addr_q + 1'b1;
            issued_d = issued_q + 1'b1;
        end

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
        end
    end

    assign rd_addr = addr_q;

    readout_buf2 #(
        .W(DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst_pll  (rst_pll),
        .flush    (flush),
        .push     (push),
        .push_data(rd_data),
        .pop      (pop),
        .count    (buf_count),
        .head     (buf_head)
    );

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - scoreboard bench for capture_readout
module tb_capture_readout;

    logic       clk = 1'b0;
    logic       rst_pll = 1'b0;
    logic       cap_done = 1'b0;
    logic [9:0] start_addr = '0;
    logic       abort = 1'b0;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       done;

    capture_readout dut (
        .clk       (clk),
        .rst_pll   (rst_pll),
        .cap_done  (cap_done),
        .start_addr(start_addr),
        .abort     (abort),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [1024];
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int checks = 0;
    int errors = 0;
    int ready_duty = 100;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int last_beat_cyc = -10;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = '0;
    logic       abort_prev = 1'b0;
    logic [7:0] exp_q [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 m_ready = ($urandom_range(0, 99) < ready_duty);
        end
    end

    // Monitor: pops the reference queue on every transferred beat.
    always @(negedge clk) begin
        if (!rst_pll) begin
            hold_pend  = 1'b0;
            abort_prev = 1'b0;
        end else begin
            cyc++;
            if (rd_en) rd_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_one_cycle_after_last_beat", last_beat_cyc, cyc - 1);
            end
            if (hold_pend && !abort_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_data);
            end
            if (m_valid && m_ready && !abort) begin
                beat_cnt++;
                last_beat_cyc = cyc;
                if (exp_q.size() == 0) chk("extra_beat", m_data, -1);
                else chk("stream_data", m_data, exp_q.pop_front());
            end
            hold_pend  = m_valid && !m_ready && !abort;
            hold_data  = m_data;
            abort_prev = abort;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // One dump: the expected byte sequence is the two sync bytes followed by
    // the circular walk of the RAM image from sa.
    task automatic run_dump(input int sa, input int duty, input int abort_at,
                            input int inject_at, input int rst_at);
        int t;
        bit ended;
        bit injected;
        exp_q.delete();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 1024; i++) exp_q.push_back(ram[(sa + i) % 1024]);
        ready_duty = duty;
        @(posedge clk);
        #1;
        rd_cnt = 0; done_cnt = 0; beat_cnt = 0;
        cap_done = 1'b1;
        start_addr = 10'(sa);
        @(posedge clk);
        #1 cap_done = 1'b0;
        start_addr = 10'($urandom);
        t = 0; ended = 0; injected = 0;
        while (!ended && t < 20000) begin
            if (done_cnt > 0) begin
                ended = 1;
            end else if (abort_at >= 0 && beat_cnt >= abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                exp_q.delete();
                chk("abort_m_valid", m_valid, 0);
                chk("abort_busy", busy, 0);
                repeat (4) @(posedge clk);
                #1 chk("abort_no_done", done_cnt, 0);
                return;
            end else if (rst_at >= 0 && beat_cnt >= rst_at) begin
                #2 rst_pll = 1'b0;
                #1 check_reset_outputs("async_rst");
                @(posedge clk);
                #1 rst_pll = 1'b1;
                exp_q.delete();
                return;
            end else begin
                if (inject_at >= 0 && beat_cnt >= inject_at && !injected) begin
                    cap_done = 1'b1;
                    start_addr = 10'(sa ^ 16'h155);
                    injected = 1;
                end else begin
                    cap_done = 1'b0;
                end
                @(posedge clk);
                #1 t++;
            end
        end
        cap_done = 1'b0;
        chk("dump_completed", ended, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("beat_count", beat_cnt, 1026);
        chk("rd_en_count", rd_cnt, 1024);
        chk("busy_after_done", busy, 0);
        if (duty == 100) chk("full_throughput", t <= 1032, 1);
        repeat (3) @(posedge clk);
        #1 chk("single_done", done_cnt, 1);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) ram[a] = 8'(a);
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_pll = 1'b1;
        repeat (2) @(posedge clk);

        run_dump(0, 100, -1, -1, -1);
        run_dump(1000, 100, -1, -1, -1);
        run_dump(1023, 100, -1, -1, -1);

        for (int a = 0; a < 1024; a++) ram[a] = 8'($urandom);
        run_dump(int'($urandom_range(0, 1023)), 30, -1, -1, -1);

        run_dump(17, 100, 102, -1, -1);
        run_dump(5, 100, -1, -1, -1);

        // abort together with cap_done while idle keeps the block idle
        @(posedge clk);
        #1 cap_done = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 cap_done = 1'b0; abort = 1'b0;
        chk("abort_wins_busy", busy, 0);
        chk("abort_wins_valid", m_valid, 0);

        run_dump(300, 60, -1, 200, -1);
        run_dump(700, 100, -1, -1, 300);
        run_dump(int'($urandom_range(0, 1023)), 50, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
Read-side engine for the logic-analyzer capture RAM. Once the sampler signals a completed capture, this block walks the 1024-deep circular buffer from a supplied start address and streams every sample out on a valid/ready byte stream towards the host link (UART/USB bridge). Each dump is prefixed with a two-byte sync header. It replaces the free-running read counter with a flow-controlled reader.

Parameters:
DATA_W, 8, sample width in bits (equals stream byte width)
ADDR_W, 10, capture RAM address width
DEPTH, 1024, samples per dump; must be at most 2**ADDR_W
HDR0, 8'h55, first sync byte
HDR1, 8'hAA, second sync byte

Ports:
clk  in  1  clock; capture RAM read clock
rst_pll  in  1  reset, asynchronous, active-low (PLL lock)
cap_done  in  1  one-cycle pulse: capture buffer is full and valid
start_addr  in  ADDR_W  oldest-sample address; sampled on the cap_done cycle
abort  in  1  synchronous cancel of the current dump
rd_en  out  1  RAM read enable
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after the rd_en cycle
m_data  out  DATA_W  stream byte
m_valid  out  1  stream valid
m_ready  in  1  stream ready (sink)
busy  out  1  dump in progress (state is not IDLE)
done  out  1  one-cycle pulse after the last sample handshake

Behaviour:
- Reset (rst_pll=0, asynchronous): state IDLE; rd_en=0; rd_addr=0; m_valid=0; m_data=0; busy=0; done=0; buffer emptied; counters cleared.
- States:
  - IDLE -> HDR0 on cap_done. On that cycle: latch start_addr into the address pointer, clear the issue and sent counters.
  - HDR0: m_data=HDR0, m_valid=1; move to HDR1 on handshake (m_valid & m_ready).
  - HDR1: m_data=HDR1, m_valid=1; move to STREAM on handshake.
  - STREAM: emit DEPTH samples; after the handshake of sample DEPTH, move to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - A beat transfers on a cycle with m_valid & m_ready.
  - Once m_valid is high, m_data and m_valid hold until that beat transfers.
  - No combinational path from m_ready to m_valid or m_data.
- RAM prefetch:
  - A 2-entry buffer holds returned samples.
  - In the HDR1 and STREAM states, the block issues a read (rd_en=1) when issued < DEPTH and (occupancy + in-flight) < 2.
  - rd_data is written into the buffer on the cycle after rd_en.
  - After each issued read, rd_addr increments and wraps from 2**ADDR_W-1 to 0.
  - m_valid in STREAM is driven from the buffer head.
  - With m_ready held at 1, the block sustains 1 sample per cycle after a startup latency of at most 2 cycles.
- Counters are ADDR_W+1 bits wide so that DEPTH=1024 is representable. The total dump is DEPTH+2 beats.
- Boundary conditions:
  - cap_done while busy: ignored. start_addr is not re-latched.
  - abort, any state except IDLE: next cycle the state is IDLE, m_valid=0, buffer flushed, in-flight data discarded, no done pulse.
  - abort together with cap_done in IDLE: abort wins and the block stays IDLE.
  - abort on the same cycle as the final handshake: abort wins and no done pulse is generated.
  - Reset mid-dump: immediate return to the reset values above.
  - start_addr = 2**ADDR_W-1: the first sample is read from that address and the second from address 0.
  - m_ready held low indefinitely: the block stalls with no loss, no duplication and no extra reads.

Decomposition:
- Shared package la_pkg holds:
  - the state enum {IDLE, HDR0, HDR1, STREAM, DONE};
  - LA_ADDR_W = 10, LA_DEPTH = 1024, LA_SYNC0 = 8'h55, LA_SYNC1 = 8'hAA, used by both the sampler and this block.
- One sub-module, readout_buf2, is natural: a 2-entry FIFO with push, pop, flush, count and head outputs.

Test Plan:
- Pattern RAM[a]=a[7:0], start_addr=0, m_ready=1 -> m_data stream is 55, AA, 00..FF repeated 4 times (1026 beats); done pulses 1 cycle after the last beat; busy falls with done.
- Same RAM, start_addr=1000 -> first sample is E8 (1000[7:0]); after FF (addr 1023) comes 00 (addr 0); last sample is E7 (addr 999).
- Random m_ready at 30% duty -> scoreboard matches the ideal sequence with no drop or duplicate; m_data is stable while m_valid & !m_ready; rd_en is asserted exactly 1024 times.
- Assert abort after 100 sample beats -> m_valid=0 next cycle, no done pulse, busy=0; a new cap_done then produces a full correct dump starting with 55.
- cap_done pulsed mid-dump with a different start_addr -> ignored; the current dump completes unchanged with a single done pulse.
- rst_pll low for 1 cycle mid-STREAM -> all outputs take their reset values asynchronously; the next cap_done runs a clean dump.
